// File: rtl/sync_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_burst_reader
// Brief    : Pops a fixed-length burst from sync_fifo onto a valid/ready stream
//            through a 2-entry skid buffer covering the FIFO read latency.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]  sent_q, sent_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  sent_inc;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  done_q, done_d;
    logic                  push;
    logic                  pop;

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = buf_q[rd_ptr_q];
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign push     = inflight_q;
    assign pop      = m_valid & m_ready;
    assign sent_inc = sent_q + 1'b1;

    // A pop this cycle frees a slot, so the buffer can refill back-to-back
    // and a ready consumer sees one word per cycle.
    assign fifo_rd_en = (state_q == READ) & ~fifo_empty & (remaining_q != '0) &
                        (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sent_d      = sent_q;
        len_d       = len_q;
        inflight_d  = fifo_rd_en;
        occ_d       = occ_q;
        buf_d       = buf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        done_d      = 1'b0;

        if (push) begin
            buf_d[wr_ptr_q] = fifo_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            sent_d   = sent_inc;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        if (fifo_rd_en) begin
            remaining_d = remaining_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_d     = READ;
                        remaining_d = burst_len;
                        len_d       = burst_len;
                        sent_d      = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (remaining_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (sent_inc == len_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            sent_q      <= '0;
            len_q       <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sent_q      <= sent_d;
            len_q       <= len_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            done_q      <= done_d;
        end
    end

endmodule
`default_nettype wire
